// File: rtl/paralelo_serial_tx_if.sv
// Link-layer symbol handshake between the link layer (master) and the
// parallel-to-serial stage (slave).
//   data_in   : 8-bit symbol offered by the link layer
//   valid_in  : data_in holds a symbol to send
//   ready_out : serializer can take a symbol this cycle
interface paralelo_serial_tx_if;
  localparam int unsigned DATA_W = 8;

  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial stage of the transmit PHY. Takes 8-bit symbols over a
// valid/ready handshake and shifts them out MSB-first, one bit per clock.
// When no user byte is pending it sends IDLE_SYM so the downstream stage sees
// a gap-free stream of 8-bit aligned symbols.
// Ports:
//   clk        : bit clock, one serial bit per rising edge
//   reset      : asynchronous active-low reset
//   bus        : symbol handshake (slave side: data_in, valid_in, ready_out)
//   serial_out : serial bit stream, MSB first
//   sym_start  : high during bit 7 (first bit) of every symbol
//   is_data    : high for all 8 bits of a user symbol, low during IDLE_SYM
module paralelo_serial_tx #(
  parameter logic [7:0] IDLE_SYM = 8'hBC
) (
  input  logic                 clk,
  input  logic                 reset,
  paralelo_serial_tx_if.slave  bus,
  output logic                 serial_out,
  output logic                 sym_start,
  output logic                 is_data
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  buf_data_q, buf_data_d;
  logic               buf_full_q, buf_full_d;
  logic               serial_d, sym_start_d, is_data_d, ready_d;
  logic               boundary_c;
  logic               accept_c;

  assign boundary_c = (bit_cnt_q == LAST_BIT);
  // ready_out low masks valid_in entirely, so an X on valid_in cannot leak in.
  assign accept_c   = bus.ready_out && bus.valid_in;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: the symbol type is decided only at a boundary, from the
  // buffer occupancy seen before that edge.
  always_comb begin
    state_d = state_q;
    if (boundary_c) begin
      state_d = buf_full_q ? ST_DATA : ST_IDLE;
    end
  end

  // Next values of the datapath and registered outputs.
  always_comb begin
    bit_cnt_d   = bit_cnt_q + CNT_W'(1);
    shift_d     = {shift_q[DATA_W-2:0], shift_q[DATA_W-1]};
    serial_d    = shift_q[DATA_W-2];
    sym_start_d = 1'b0;
    is_data_d   = is_data;
    buf_data_d  = buf_data_q;
    buf_full_d  = buf_full_q;

    if (boundary_c) begin
      shift_d     = buf_full_q ? buf_data_q : IDLE_SYM;
      serial_d    = shift_d[DATA_W-1];
      sym_start_d = 1'b1;
      is_data_d   = (state_d == ST_DATA);
      buf_full_d  = 1'b0;
    end

    // An accept needs ready_out=1, i.e. an empty buffer, so it never
    // collides with a boundary load of a buffered byte.
    if (accept_c) begin
      buf_data_d = bus.data_in;
      buf_full_d = 1'b1;
    end

    ready_d = !buf_full_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_q     <= LAST_BIT;
      shift_q       <= IDLE_SYM;
      buf_data_q    <= '0;
      buf_full_q    <= 1'b0;
      serial_out    <= 1'b0;
      sym_start     <= 1'b0;
      is_data       <= 1'b0;
      bus.ready_out <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      buf_data_q    <= buf_data_d;
      buf_full_q    <= buf_full_d;
      serial_out    <= serial_d;
      sym_start     <= sym_start_d;
      is_data       <= is_data_d;
      bus.ready_out <= ready_d;
    end
  end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Self-checking bench for paralelo_serial_tx. A symbol-level model (edge count
// modulo 8 plus a queue of accepted bytes) predicts every output each cycle.
module tb_paralelo_serial_tx;

  localparam logic [7:0] IDLE = 8'hBC;

  logic clk;
  logic reset;
  logic serial_out;
  logic sym_start;
  logic is_data;

  paralelo_serial_tx_if bus ();

  paralelo_serial_tx #(.IDLE_SYM(IDLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .serial_out (serial_out),
    .sym_start  (sym_start),
    .is_data    (is_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model state.
  logic [7:0] q[$];
  logic [7:0] cur;
  int         m_edges;
  logic       e_ser, e_ss, e_id, e_rdy;

  task automatic model_reset();
    q.delete();
    cur     = IDLE;
    m_edges = 0;
    e_ser   = 1'b0;
    e_ss    = 1'b0;
    e_id    = 1'b0;
    e_rdy   = 1'b0;
  endtask

  // One clock edge: advance the model with the inputs presented before it,
  // then settle 1 time unit past the edge.
  task automatic tick();
    bit acc;
    int pos;
    acc = (bus.valid_in === 1'b1) && (e_rdy === 1'b1);
    @(posedge clk);
    pos = m_edges % 8;
    if (pos == 0) begin
      if (q.size() > 0) begin
        cur  = q.pop_front();
        e_id = 1'b1;
      end else begin
        cur  = IDLE;
        e_id = 1'b0;
      end
    end
    if (acc) q.push_back(bus.data_in);
    e_ser = cur[7 - pos];
    e_ss  = (pos == 0);
    e_rdy = (q.size() == 0);
    m_edges++;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] cap;
    int          nd;
    reset        = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({serial_out, sym_start, is_data, bus.ready_out} !== 4'b0000)
      $display("FAIL reset_vals got=%b exp=0000", {serial_out, sym_start, is_data, bus.ready_out});
    else n_pass++;
    reset = 1'b1;
    model_reset();
    cap = '0;
    nd  = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      n_total++;
      if ({serial_out, sym_start, is_data, bus.ready_out} !== {e_ser, e_ss, e_id, e_rdy})
        $display("FAIL idle_stream cyc=%0d got=%b exp=%b", i,
                 {serial_out, sym_start, is_data, bus.ready_out}, {e_ser, e_ss, e_id, e_rdy});
      else n_pass++;
      cap = {cap[30:0], serial_out};
      if (is_data !== 1'b0) nd++;
    end
    n_total++;
    if (cap !== {4{IDLE}}) $display("FAIL idle_pattern got=%h exp=%h", cap, {4{IDLE}});
    else n_pass++;
    n_total++;
    if (nd !== 0) $display("FAIL idle_is_data got=%0d exp=0", nd);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [7:0] cap;
    int         nbits;
    repeat (3) begin
      tick();
      n_total++;
      if ({serial_out, sym_start, is_data, bus.ready_out} !== {e_ser, e_ss, e_id, e_rdy})
        $display("FAIL single_pre got=%b exp=%b",
                 {serial_out, sym_start, is_data, bus.ready_out}, {e_ser, e_ss, e_id, e_rdy});
      else n_pass++;
    end
    bus.data_in  = 8'h7C;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    n_total++;
    if (bus.ready_out !== 1'b0) $display("FAIL single_ready_drop got=%b exp=0", bus.ready_out);
    else n_pass++;
    cap   = '0;
    nbits = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      n_total++;
      if ({serial_out, sym_start, is_data, bus.ready_out} !== {e_ser, e_ss, e_id, e_rdy})
        $display("FAIL single_stream cyc=%0d got=%b exp=%b", i,
                 {serial_out, sym_start, is_data, bus.ready_out}, {e_ser, e_ss, e_id, e_rdy});
      else n_pass++;
      if (is_data === 1'b1) begin
        cap = {cap[6:0], serial_out};
        nbits++;
      end
    end
    n_total++;
    if (cap !== 8'h7C || nbits !== 8)
      $display("FAIL single_byte got=%h/%0d bits exp=7c/8 bits", cap, nbits);
    else n_pass++;
  endtask

  // Bring the model to the point where the next edge is a boundary.
  task automatic align_boundary();
    for (int i = 0; i < 8 && (m_edges % 8) != 0; i++) begin
      tick();
      n_total++;
      if ({serial_out, sym_start, is_data, bus.ready_out} !== {e_ser, e_ss, e_id, e_rdy})
        $display("FAIL align got=%b exp=%b",
                 {serial_out, sym_start, is_data, bus.ready_out}, {e_ser, e_ss, e_id, e_rdy});
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] cap;
    int          nbits, n_acc, low_cnt, start1, start2, nstarts;
    bit          acc;
    align_boundary();
    bus.data_in  = 8'hA5;
    bus.valid_in = 1'b1;
    cap = '0; nbits = 0; n_acc = 0; low_cnt = 0; start1 = -1; start2 = -1; nstarts = 0;
    for (int i = 0; i < 40; i++) begin
      acc = (bus.valid_in === 1'b1) && (e_rdy === 1'b1);
      tick();
      n_total++;
      if ({serial_out, sym_start, is_data, bus.ready_out} !== {e_ser, e_ss, e_id, e_rdy})
        $display("FAIL b2b_stream cyc=%0d got=%b exp=%b", i,
                 {serial_out, sym_start, is_data, bus.ready_out}, {e_ser, e_ss, e_id, e_rdy});
      else n_pass++;
      if (acc) begin
        n_acc++;
        if (n_acc == 1) bus.data_in = 8'h3C;
        else bus.valid_in = 1'b0;
      end
      if (n_acc == 1 && bus.ready_out === 1'b0) low_cnt++;
      if (is_data === 1'b1) begin
        cap = {cap[14:0], serial_out};
        nbits++;
        if (sym_start === 1'b1) begin
          nstarts++;
          if (start1 < 0) start1 = i;
          else start2 = i;
        end
      end
    end
    n_total++;
    if (cap !== 16'hA53C || nbits !== 16)
      $display("FAIL b2b_bytes got=%h/%0d bits exp=a53c/16 bits", cap, nbits);
    else n_pass++;
    n_total++;
    if (nstarts !== 2 || start2 - start1 !== 8)
      $display("FAIL b2b_gap got=%0d syms spacing %0d exp=2 syms spacing 8", nstarts, start2 - start1);
    else n_pass++;
    n_total++;
    if (low_cnt !== 8) $display("FAIL b2b_ready_low got=%0d exp=8", low_cnt);
    else n_pass++;
  endtask

  task automatic test_boundary_accept();
    logic [7:0] cap;
    int         nbits;
    align_boundary();
    bus.data_in  = 8'hFF;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    n_total++;
    if ({serial_out, sym_start, is_data, bus.ready_out} !== 4'b1100)
      $display("FAIL bnd_loads_idle got=%b exp=1100", {serial_out, sym_start, is_data, bus.ready_out});
    else n_pass++;
    cap = '0;
    nbits = 0;
    for (int i = 0; i < 23; i++) begin
      tick();
      n_total++;
      if ({serial_out, sym_start, is_data, bus.ready_out} !== {e_ser, e_ss, e_id, e_rdy})
        $display("FAIL bnd_stream cyc=%0d got=%b exp=%b", i,
                 {serial_out, sym_start, is_data, bus.ready_out}, {e_ser, e_ss, e_id, e_rdy});
      else n_pass++;
      if (i >= 7 && i < 15 && is_data === 1'b1) begin
        cap = {cap[6:0], serial_out};
        nbits++;
      end
    end
    n_total++;
    if (cap !== 8'hFF || nbits !== 8)
      $display("FAIL bnd_next_sym got=%h/%0d bits exp=ff/8 bits", cap, nbits);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    logic [7:0] cap;
    int         nd;
    align_boundary();
    bus.data_in  = 8'h5A;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    repeat (8) tick();
    n_total++;
    if ({sym_start, is_data, serial_out} !== 3'b110)
      $display("FAIL abort_5a_start got=%b exp=110", {sym_start, is_data, serial_out});
    else n_pass++;
    bus.data_in  = 8'h99;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    repeat (2) tick();
    n_total++;
    if ({serial_out, sym_start, is_data, bus.ready_out} !== {e_ser, e_ss, e_id, e_rdy} ||
        e_rdy !== 1'b0 || e_ser !== 1'b1)
      $display("FAIL abort_pre got=%b exp=%b",
               {serial_out, sym_start, is_data, bus.ready_out}, {e_ser, e_ss, e_id, e_rdy});
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_total++;
    if ({serial_out, sym_start, is_data, bus.ready_out} !== 4'b0000 || clk !== 1'b1)
      $display("FAIL abort_async got=%b exp=0000", {serial_out, sym_start, is_data, bus.ready_out});
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    cap = '0;
    nd  = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      n_total++;
      if ({serial_out, sym_start, is_data, bus.ready_out} !== {e_ser, e_ss, e_id, e_rdy})
        $display("FAIL abort_restart cyc=%0d got=%b exp=%b", i,
                 {serial_out, sym_start, is_data, bus.ready_out}, {e_ser, e_ss, e_id, e_rdy});
      else n_pass++;
      if (i < 8) cap = {cap[6:0], serial_out};
      if (is_data !== 1'b0) nd++;
    end
    n_total++;
    if (cap !== IDLE || nd !== 0)
      $display("FAIL abort_dropped got=%h/%0d data cycles exp=bc/0", cap, nd);
    else n_pass++;
  endtask

  task automatic test_random();
    int n_acc, n_dsym;
    bit acc;
    n_acc  = 0;
    n_dsym = 0;
    for (int i = 0; i < 400; i++) begin
      if (e_rdy === 1'b1) begin
        bus.valid_in = 1'($urandom_range(0, 1));
        bus.data_in  = 8'($urandom);
      end else begin
        bus.data_in  = 8'($urandom);
        if ($urandom_range(0, 3) == 0) bus.valid_in = 1'bx;
        else bus.valid_in = 1'($urandom_range(0, 1));
      end
      acc = (bus.valid_in === 1'b1) && (e_rdy === 1'b1);
      if (acc) n_acc++;
      tick();
      n_total++;
      if ({serial_out, sym_start, is_data, bus.ready_out} !== {e_ser, e_ss, e_id, e_rdy})
        $display("FAIL random_stream cyc=%0d got=%b exp=%b", i,
                 {serial_out, sym_start, is_data, bus.ready_out}, {e_ser, e_ss, e_id, e_rdy});
      else n_pass++;
      if (sym_start === 1'b1 && is_data === 1'b1) n_dsym++;
    end
    bus.valid_in = 1'b0;
    n_total++;
    if (n_dsym !== n_acc - q.size())
      $display("FAIL random_count got=%0d sent exp=%0d", n_dsym, n_acc - q.size());
    else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_boundary_accept();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/paralelo_serial_tx.md
Name: paralelo_serial_tx

Overview:
Parallel-to-serial stage of the transmit PHY. It sits directly upstream of the serial-paralelo transmitter and drives the serial bit line that stage samples.
- Accepts 8-bit symbols from the link layer through a valid/ready handshake.
- Shifts each symbol out MSB-first, one bit per clock.
- Inserts the COM idle symbol (0xBC) whenever no user byte is pending, so the downstream stage always sees a continuous, aligned symbol stream.

Parameters:
IDLE_SYM, 8'hBC, filler symbol sent when no data is pending (COM/K28.5 pattern).
DATA_W, 8, symbol width; fixed at 8, not to be overridden.

Ports:
clk  input  1  bit clock; one serial bit per rising edge.
reset  input  1  asynchronous, active-low reset; 0 = in reset.
data_in  input  8  symbol from link layer.
valid_in  input  1  data_in holds a symbol to send.
ready_out  output  1  block can accept a symbol this cycle.
serial_out  output  1  serial bit stream, MSB of each symbol first.
sym_start  output  1  high during the first bit (bit 7) of every symbol.
is_data  output  1  high for all 8 bits of a user symbol; low during IDLE_SYM.

Behaviour:
- One clock (clk) and one asynchronous active-low reset (reset). All outputs are registered.
- Reset (reset=0):
  - serial_out=0, ready_out=0, sym_start=0, is_data=0.
  - bit_cnt=7, hold buffer empty, shift register = IDLE_SYM.
  - Asserting reset mid-symbol aborts that symbol immediately, discards any buffered byte and takes effect without waiting for a clock edge.
- Internal state:
  - 3-bit bit_cnt.
  - 8-bit shift register.
  - One-entry hold buffer (buf_data, buf_full).
  - State register with two states, IDLE (sending filler) and DATA (sending user symbol).
- Boundary cycle = any cycle with bit_cnt==7. The first edge after reset release is a boundary.
- At a boundary edge:
  - If buf_full: shift register and serial_out are loaded from buf_data (serial_out <= buf_data[7]); state DATA; is_data<=1; buf_full<=0.
  - Else: load IDLE_SYM the same way; state IDLE; is_data<=0.
  - In both cases: bit_cnt<=0, sym_start<=1.
- Non-boundary edge: serial_out <= next lower bit of the current symbol; bit_cnt increments; sym_start<=0; is_data holds.
- Symbol timing: each symbol occupies exactly 8 consecutive cycles, with no gaps between symbols. bit_cnt wraps 7->0.
- Handshake:
  - A transfer occurs on an edge where valid_in=1 and ready_out=1; data_in is written into the buffer and buf_full<=1.
  - ready_out is registered as the next-state value of !buf_full, so it drops on the edge after an accept.
  - At a boundary, the load decision uses buf_full as it was before that edge. A byte accepted on a boundary edge is therefore sent in the following symbol, not the current one.
  - A boundary load that empties the buffer raises ready_out on that same edge.
  - data_in is ignored when ready_out=0. valid_in may be held high and the block must not drop or duplicate the byte.
- Latency: a byte accepted while the buffer is empty appears on serial_out starting at the next boundary edge, after 1 to 8 clocks depending on the current bit_cnt.
- No X propagation: valid_in=X while ready_out=0 must not change state.

Test Plan:
1. Reset held low for 3 clocks, then released with valid_in=0 -> serial_out repeats 1,0,1,1,1,1,0,0; sym_start high on every 8th cycle starting at the first post-reset edge; is_data=0 throughout.
2. Single byte 0x7C presented mid-COM -> ready_out drops after accept; current COM completes; next 8 bits are 0,1,1,1,1,1,0,0 with is_data=1; then COM resumes.
3. Back-to-back 0xA5 then 0x3C with valid_in held high -> serial stream 10100101 00111100 with no COM between them; each byte sent exactly once; ready_out low for 8 cycles between accepts.
4. valid_in asserted exactly on a boundary edge with data 0xFF -> that cycle loads IDLE_SYM; 0xFF (eight 1s) follows in the next symbol.
5. reset driven low at bit_cnt=3 of a 0x5A data symbol with a byte buffered -> outputs go to 0 immediately without a clock; after release the stream restarts with COM and the buffered byte is not sent.
